// File: rtl/wbdemux_if.sv
// Pipelined Wishbone B4 bus bundle: one request/response channel between a
// master and a slave. The master modport drives the request side; the slave
// modport drives the response side.
interface wbdemux_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW/8-1:0] sel;
  logic            ack;
  logic            stall;
  logic            err;
  logic [DW-1:0]   dat_r;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  ack, stall, err, dat_r
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output ack, stall, err, dat_r
  );
endinterface

// File: rtl/wbdemux.sv
// Pipelined Wishbone B4 one-to-two demultiplexer. A single master is routed
// to slave A or slave B by address decode. Requests only go to the currently
// selected slave; changing slave waits until every outstanding request has
// been answered, so acknowledgements always return in order from one slave.
// Addresses matching neither slave are accepted locally and answered with a
// one-cycle bus error.
module wbdemux #(
  parameter int            DW        = 32,
  parameter int            AW        = 32,
  parameter logic [AW-1:0] A_BASE    = 'h0,
  parameter logic [AW-1:0] A_MASK    = 'h8000_0000,
  parameter logic [AW-1:0] B_BASE    = 'h8000_0000,
  parameter logic [AW-1:0] B_MASK    = 'h8000_0000,
  parameter int            LGMAXPEND = 3
) (
  input  logic     i_clk,
  input  logic     i_reset_n,
  wbdemux_if.slave  i_m,
  wbdemux_if.master o_a,
  wbdemux_if.master o_b
);

  // Selected slave; SEL_NONE doubles as the "unmapped" decode result.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_A    = 2'd1,
    SEL_B    = 2'd2
  } sel_e;

  sel_e                 r_sel;
  logic [LGMAXPEND-1:0] r_pend;
  logic                 r_err;

  sel_e                 w_tgt;
  logic                 w_req;
  logic                 w_full;
  logic                 w_a_stb;
  logic                 w_b_stb;
  logic                 w_acc_map;
  logic                 w_acc_unm;
  logic                 w_switch;
  logic                 w_sack;
  logic                 w_serr;
  logic                 w_dec;
  logic [DW-1:0]        w_sdat;

  // Address decode; slave A wins where the two windows overlap.
  always_comb begin
    w_tgt = SEL_NONE;
    if ((i_m.adr & A_MASK) == A_BASE)
      w_tgt = SEL_A;
    else if ((i_m.adr & B_MASK) == B_BASE)
      w_tgt = SEL_B;
  end

  assign w_req     = i_m.cyc && i_m.stb;
  assign w_full    = (r_pend == '1);
  assign w_a_stb   = w_req && (w_tgt == SEL_A) && (r_sel == SEL_A) && !w_full;
  assign w_b_stb   = w_req && (w_tgt == SEL_B) && (r_sel == SEL_B) && !w_full;
  assign w_acc_map = (w_a_stb && !o_a.stall) || (w_b_stb && !o_b.stall);
  assign w_acc_unm = w_req && (w_tgt == SEL_NONE) && (r_pend == '0);
  assign w_switch  = w_req && (w_tgt != SEL_NONE) && (w_tgt != r_sel) && (r_pend == '0);

  // Response mux: only the selected slave may answer the master.
  always_comb begin
    w_sack = 1'b0;
    w_serr = 1'b0;
    w_sdat = o_a.dat_r;
    case (r_sel)
      SEL_A: begin
        w_sack = o_a.ack;
        w_serr = o_a.err;
        w_sdat = o_a.dat_r;
      end
      SEL_B: begin
        w_sack = o_b.ack;
        w_serr = o_b.err;
        w_sdat = o_b.dat_r;
      end
      default: ;
    endcase
  end

  // A stray ack with nothing outstanding must not wrap the counter.
  assign w_dec = w_sack && (r_pend != '0);

  // Master-side responses.
  assign i_m.stall = i_m.stb && !(w_acc_map || w_acc_unm);
  assign i_m.ack   = i_m.cyc && w_sack;
  assign i_m.err   = r_err || (i_m.cyc && w_serr);
  assign i_m.dat_r = w_sdat;

  // Slave A request side; address/data/selects are broadcast.
  assign o_a.cyc   = i_m.cyc && (r_sel == SEL_A);
  assign o_a.stb   = w_a_stb;
  assign o_a.we    = i_m.we;
  assign o_a.adr   = i_m.adr;
  assign o_a.dat_w = i_m.dat_w;
  assign o_a.sel   = i_m.sel;

  // Slave B request side.
  assign o_b.cyc   = i_m.cyc && (r_sel == SEL_B);
  assign o_b.stb   = w_b_stb;
  assign o_b.we    = i_m.we;
  assign o_b.adr   = i_m.adr;
  assign o_b.dat_w = i_m.dat_w;
  assign o_b.sel   = i_m.sel;

  // Slave selection, outstanding-request count and local error pulse.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sel  <= SEL_NONE;
      r_pend <= '0;
      r_err  <= 1'b0;
    end else if (!i_m.cyc) begin
      r_sel  <= SEL_NONE;
      r_pend <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_acc_unm;
      if (w_switch)
        r_sel <= w_tgt;
      // A slave error aborts everything in flight but keeps the selection.
      if (w_serr)
        r_pend <= '0;
      else if (w_acc_map && !w_dec)
        r_pend <= r_pend + LGMAXPEND'(1);
      else if (!w_acc_map && w_dec)
        r_pend <= r_pend - LGMAXPEND'(1);
    end
  end

endmodule

// File: tb/tb_wbdemux.sv
// Directed bench for wbdemux. dut0 uses the default 1-bit address split;
// dut1 uses two-bit windows leaving 'hC000_0000 unmapped and a 2-bit
// outstanding counter. Inputs change 1 time unit after a rising edge and
// outputs are sampled 2 units later.
module tb_wbdemux;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  wbdemux_if #(.DW(32), .AW(32)) m0 ();
  wbdemux_if #(.DW(32), .AW(32)) a0 ();
  wbdemux_if #(.DW(32), .AW(32)) b0 ();
  wbdemux_if #(.DW(32), .AW(32)) m1 ();
  wbdemux_if #(.DW(32), .AW(32)) a1 ();
  wbdemux_if #(.DW(32), .AW(32)) b1 ();

  wbdemux #(.DW(32), .AW(32)) dut0 (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_m       (m0),
    .o_a       (a0),
    .o_b       (b0)
  );

  wbdemux #(
    .DW        (32),
    .AW        (32),
    .A_BASE    (32'h0000_0000),
    .A_MASK    (32'hC000_0000),
    .B_BASE    (32'h4000_0000),
    .B_MASK    (32'hC000_0000),
    .LGMAXPEND (2)
  ) dut1 (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_m       (m1),
    .o_a       (a1),
    .o_b       (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0.cyc = 0; m0.stb = 0; m0.we = 0; m0.adr = '0; m0.dat_w = '0; m0.sel = '0;
    m1.cyc = 0; m1.stb = 0; m1.we = 0; m1.adr = '0; m1.dat_w = '0; m1.sel = '0;
    a0.ack = 0; a0.stall = 0; a0.err = 0; a0.dat_r = '0;
    b0.ack = 0; b0.stall = 0; b0.err = 0; b0.dat_r = '0;
    a1.ack = 0; a1.stall = 0; a1.err = 0; a1.dat_r = '0;
    b1.ack = 0; b1.stall = 0; b1.err = 0; b1.dat_r = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_n  = 1'b0;
    m0.stb = 1'b1;
    #3;
    checks++; if (m0.stall !== 1'b1) begin errors++; $display("FAIL rst_stall_eq_stb got %0b exp 1", m0.stall); end
    checks++; if (a0.cyc !== 1'b0 || b0.cyc !== 1'b0) begin errors++; $display("FAIL rst_cyc got a=%0b b=%0b exp 0 0", a0.cyc, b0.cyc); end
    checks++; if (a0.stb !== 1'b0 || b0.stb !== 1'b0) begin errors++; $display("FAIL rst_stb got a=%0b b=%0b exp 0 0", a0.stb, b0.stb); end
    checks++; if (m0.ack !== 1'b0 || m0.err !== 1'b0) begin errors++; $display("FAIL rst_ack_err got ack=%0b err=%0b exp 0 0", m0.ack, m0.err); end
    m0.stb = 1'b0;
    #1;
    checks++; if (m0.stall !== 1'b0) begin errors++; $display("FAIL rst_stall_nostb got %0b exp 0", m0.stall); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_first_write();
    m0.cyc = 1; m0.stb = 1; m0.we = 1; m0.adr = 32'h0000_0010;
    m0.dat_w = 32'hDEAD_BEEF; m0.sel = 4'hF;
    #2;
    checks++; if (m0.stall !== 1'b1) begin errors++; $display("FAIL fw_bubble_stall got %0b exp 1", m0.stall); end
    checks++; if (a0.cyc !== 1'b0 || a0.stb !== 1'b0) begin errors++; $display("FAIL fw_bubble_a got cyc=%0b stb=%0b exp 0 0", a0.cyc, a0.stb); end
    step();
    #2;
    checks++; if (a0.cyc !== 1'b1 || a0.stb !== 1'b1) begin errors++; $display("FAIL fw_issue_a got cyc=%0b stb=%0b exp 1 1", a0.cyc, a0.stb); end
    checks++; if (m0.stall !== 1'b0) begin errors++; $display("FAIL fw_issue_stall got %0b exp 0", m0.stall); end
    checks++; if (b0.cyc !== 1'b0) begin errors++; $display("FAIL fw_b_cyc got %0b exp 0", b0.cyc); end
    checks++; if (a0.adr !== 32'h0000_0010 || a0.dat_w !== 32'hDEAD_BEEF || a0.we !== 1'b1 || a0.sel !== 4'hF) begin errors++; $display("FAIL fw_bcast got adr=%h dat=%h we=%0b sel=%h exp 00000010 deadbeef 1 f", a0.adr, a0.dat_w, a0.we, a0.sel); end
    step();
    m0.stb = 0; a0.ack = 1; a0.dat_r = 32'h0000_1234;
    #2;
    checks++; if (m0.ack !== 1'b1) begin errors++; $display("FAIL fw_ack got %0b exp 1", m0.ack); end
    checks++; if (dut0.r_pend !== 3'd1) begin errors++; $display("FAIL fw_pend got %0d exp 1", dut0.r_pend); end
    step();
    a0.ack = 0; m0.cyc = 0; m0.we = 0;
    #2;
    checks++; if (dut0.r_pend !== 3'd0) begin errors++; $display("FAIL fw_pend_drain got %0d exp 0", dut0.r_pend); end
    step();
  endtask

  task automatic test_back_to_back();
    int unsigned exp_pend [8] = '{0, 0, 1, 2, 2, 2, 1, 0};
    logic exp_stall, exp_stb, exp_ack;
    logic [31:0] exp_dat;
    for (int c = 0; c < 8; c++) begin
      m0.cyc = 1;
      m0.stb = (c <= 4);
      m0.adr = 32'h8000_0000 + 32'((c == 0) ? 0 : 4 * (c - 1));
      b0.ack = (c >= 3 && c <= 6);
      b0.dat_r = 32'hB000_0000 + 32'((c >= 3) ? c - 3 : 0);
      exp_stall = (c == 0);
      exp_stb   = (c >= 1 && c <= 4);
      exp_ack   = (c >= 3 && c <= 6);
      exp_dat   = 32'hB000_0000 + 32'(c - 3);
      #2;
      checks++; if (m0.stall !== exp_stall) begin errors++; $display("FAIL b2b_stall c=%0d got %0b exp %0b", c, m0.stall, exp_stall); end
      checks++; if (b0.stb !== exp_stb) begin errors++; $display("FAIL b2b_stb c=%0d got %0b exp %0b", c, b0.stb, exp_stb); end
      checks++; if (m0.ack !== exp_ack) begin errors++; $display("FAIL b2b_ack c=%0d got %0b exp %0b", c, m0.ack, exp_ack); end
      checks++; if (32'(dut0.r_pend) !== exp_pend[c]) begin errors++; $display("FAIL b2b_pend c=%0d got %0d exp %0d", c, dut0.r_pend, exp_pend[c]); end
      if (exp_ack) begin
        checks++; if (m0.dat_r !== exp_dat) begin errors++; $display("FAIL b2b_dat c=%0d got %h exp %h", c, m0.dat_r, exp_dat); end
      end
      step();
    end
    b0.ack = 0; m0.cyc = 0; m0.stb = 0;
    step();
  endtask

  task automatic test_cross();
    m0.cyc = 1; m0.stb = 1; m0.adr = 32'h0000_0020;
    #2;
    checks++; if (m0.stall !== 1'b1) begin errors++; $display("FAIL x_bubble_a got %0b exp 1", m0.stall); end
    step();
    #2;
    checks++; if (m0.stall !== 1'b0 || a0.stb !== 1'b1) begin errors++; $display("FAIL x_issue_a got stall=%0b stb=%0b exp 0 1", m0.stall, a0.stb); end
    step();
    m0.adr = 32'h8000_0000;
    #2;
    checks++; if (m0.stall !== 1'b1 || b0.stb !== 1'b0 || a0.stb !== 1'b0) begin errors++; $display("FAIL x_wait1 got stall=%0b bstb=%0b astb=%0b exp 1 0 0", m0.stall, b0.stb, a0.stb); end
    step();
    b0.ack = 1;
    #2;
    checks++; if (m0.ack !== 1'b0 || m0.stall !== 1'b1) begin errors++; $display("FAIL x_stray_b got ack=%0b stall=%0b exp 0 1", m0.ack, m0.stall); end
    step();
    b0.ack = 0; a0.ack = 1; a0.dat_r = 32'h0000_AAAA;
    #2;
    checks++; if (m0.ack !== 1'b1 || m0.dat_r !== 32'h0000_AAAA) begin errors++; $display("FAIL x_ack_a got ack=%0b dat=%h exp 1 0000aaaa", m0.ack, m0.dat_r); end
    checks++; if (m0.stall !== 1'b1 || b0.stb !== 1'b0) begin errors++; $display("FAIL x_wait_ack got stall=%0b bstb=%0b exp 1 0", m0.stall, b0.stb); end
    step();
    a0.ack = 0;
    #2;
    checks++; if (m0.stall !== 1'b1 || b0.stb !== 1'b0 || b0.cyc !== 1'b0) begin errors++; $display("FAIL x_bubble_b got stall=%0b bstb=%0b bcyc=%0b exp 1 0 0", m0.stall, b0.stb, b0.cyc); end
    step();
    #2;
    checks++; if (b0.cyc !== 1'b1 || a0.cyc !== 1'b0 || b0.stb !== 1'b1 || m0.stall !== 1'b0) begin errors++; $display("FAIL x_issue_b got bcyc=%0b acyc=%0b bstb=%0b stall=%0b exp 1 0 1 0", b0.cyc, a0.cyc, b0.stb, m0.stall); end
    step();
    m0.stb = 0; a0.ack = 1;
    #2;
    checks++; if (m0.ack !== 1'b0) begin errors++; $display("FAIL x_stray_a got %0b exp 0", m0.ack); end
    step();
    a0.ack = 0; m0.cyc = 0;
    step();
  endtask

  task automatic test_unmapped();
    m1.cyc = 1; m1.stb = 1; m1.adr = 32'hC000_0000;
    #2;
    checks++; if (m1.stall !== 1'b0) begin errors++; $display("FAIL um_stall got %0b exp 0", m1.stall); end
    checks++; if (a1.stb !== 1'b0 || b1.stb !== 1'b0) begin errors++; $display("FAIL um_stb got a=%0b b=%0b exp 0 0", a1.stb, b1.stb); end
    checks++; if (m1.err !== 1'b0) begin errors++; $display("FAIL um_err_early got %0b exp 0", m1.err); end
    step();
    m1.stb = 0;
    #2;
    checks++; if (m1.err !== 1'b1) begin errors++; $display("FAIL um_err_pulse got %0b exp 1", m1.err); end
    step();
    #2;
    checks++; if (m1.err !== 1'b0) begin errors++; $display("FAIL um_err_end got %0b exp 0", m1.err); end
    m1.cyc = 0;
    step();
  endtask

  task automatic test_maxpend();
    m1.cyc = 1; m1.stb = 1; m1.adr = 32'h0000_0100;
    #2;
    checks++; if (m1.stall !== 1'b1) begin errors++; $display("FAIL mp_bubble got %0b exp 1", m1.stall); end
    step();
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++; if (m1.stall !== 1'b0 || a1.stb !== 1'b1) begin errors++; $display("FAIL mp_accept k=%0d got stall=%0b stb=%0b exp 0 1", k, m1.stall, a1.stb); end
      step();
    end
    #2;
    checks++; if (dut1.r_pend !== 2'd3) begin errors++; $display("FAIL mp_pend_max got %0d exp 3", dut1.r_pend); end
    checks++; if (m1.stall !== 1'b1 || a1.stb !== 1'b0) begin errors++; $display("FAIL mp_full got stall=%0b stb=%0b exp 1 0", m1.stall, a1.stb); end
    step();
    m1.cyc = 0; m1.stb = 0;
    #2;
    checks++; if (a1.cyc !== 1'b0) begin errors++; $display("FAIL mp_cyc_drop got %0b exp 0", a1.cyc); end
    step();
    a1.ack = 1;
    #2;
    checks++; if (dut1.r_pend !== 2'd0) begin errors++; $display("FAIL mp_pend_clr got %0d exp 0", dut1.r_pend); end
    checks++; if (m1.ack !== 1'b0) begin errors++; $display("FAIL mp_late_ack_idle got %0b exp 0", m1.ack); end
    m1.cyc = 1;
    #1;
    checks++; if (m1.ack !== 1'b0 || a1.cyc !== 1'b0) begin errors++; $display("FAIL mp_late_ack_cyc got ack=%0b acyc=%0b exp 0 0", m1.ack, a1.cyc); end
    step();
    a1.ack = 0; m1.cyc = 0;
    step();
  endtask

  task automatic test_reset_mid();
    m0.cyc = 1; m0.stb = 1; m0.adr = 32'h0000_0000;
    step();
    step();
    step();
    m0.stb = 0;
    #2;
    checks++; if (dut0.r_pend !== 3'd2 || a0.cyc !== 1'b1) begin errors++; $display("FAIL rm_pre got pend=%0d acyc=%0b exp 2 1", dut0.r_pend, a0.cyc); end
    rst_n = 0;
    #1;
    a0.ack = 1;
    #1;
    checks++; if (a0.cyc !== 1'b0) begin errors++; $display("FAIL rm_cyc_drop got %0b exp 0", a0.cyc); end
    checks++; if (m0.err !== 1'b0 || m0.ack !== 1'b0) begin errors++; $display("FAIL rm_resp got err=%0b ack=%0b exp 0 0", m0.err, m0.ack); end
    checks++; if (dut0.r_pend !== 3'd0) begin errors++; $display("FAIL rm_pend got %0d exp 0", dut0.r_pend); end
    step();
    rst_n = 1; a0.ack = 0; m0.stb = 1;
    #2;
    checks++; if (m0.stall !== 1'b1 || a0.stb !== 1'b0) begin errors++; $display("FAIL rm_bubble got stall=%0b stb=%0b exp 1 0", m0.stall, a0.stb); end
    step();
    #2;
    checks++; if (m0.stall !== 1'b0 || a0.stb !== 1'b1) begin errors++; $display("FAIL rm_accept got stall=%0b stb=%0b exp 0 1", m0.stall, a0.stb); end
    step();
    m0.cyc = 0; m0.stb = 0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_first_write();
    test_back_to_back();
    test_cross();
    test_unmapped();
    test_maxpend();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
